micro_sequencer: RTL and testbench
==================================

// Module: micro_sequencer
// PURPOSE
// - Owns the micro-program counter (uPC) of the microcoded control unit: registers the next
//   control-store address each cycle from the microword next-address field.
// - Sources are the sequential field, the Z-conditional branch (MSB flip) and the opcode
//   dispatch from the instruction register.
// - Adds start/halt control, memory-wait stalling and an optional micro-subroutine stack.
// - Sits between the instruction register / ALU flags and the combinational control-store ROM.
// PARAMETERS
// - AW           8      uPC / control-store address width
// - RESET_ADDR   8'h00  uPC value at reset and on START (fetch microroutine entry)
// - STACK_DEPTH  4      return-stack entries (used only with MICRO_STACK_EN)
// PORTS
// - clk        in   1   single system clock, rising edge
// - rst        in   1   synchronous, active-high reset
// - START      in   1   leave IDLE/HALTED and begin at RESET_ADDR
// - HALT       in   1   microword halt bit
// - MEMWAIT    in   1   memory not ready; freeze the sequencer
// - EN         in   1   microword dispatch enable (next uPC = IROUT)
// - ZEN        in   1   microword Z-branch enable
// - Z          in   1   ALU zero flag
// - CALL       in   1   microword call bit (stack build only)
// - RET        in   1   microword return bit (stack build only)
// - MicroAdd   in   AW  microword next-address field
// - IROUT      in   AW  instruction register, opcode dispatch address
// - MicroPC    out  AW  registered address to the control store
// - RUNNING    out  1   1 in RUN or WAIT
// - STALL      out  1   1 in WAIT
// - STACK_ERR  out  1   one-cycle pulse on stack overflow, underflow or CALL&RET conflict
// BEHAVIOUR
// - Reset: state=IDLE, MicroPC=RESET_ADDR, RUNNING=0, STALL=0, STACK_ERR=0, stack empty.
// - States: IDLE, RUN, WAIT, HALTED. The ROM is combinational; the microword at MicroPC is
//   valid in the same cycle. The next MicroPC is registered one cycle later.
// - IDLE: hold RESET_ADDR. START -> RUN, with MicroPC=RESET_ADDR.
// - RUN, per-cycle priority: rst > MEMWAIT > HALT > address select.
//   - MEMWAIT=1 -> WAIT; MicroPC held.
//   - HALT=1 -> HALTED; MicroPC held.
// - Address select (RUN only), highest first:
//   - EN -> IROUT
//   - ZEN&Z -> {~MicroAdd[AW-1], MicroAdd[AW-2:0]}
//   - otherwise -> MicroAdd
// - WAIT: MicroPC held, STALL=1; the same microword stays presented. MEMWAIT=0 -> RUN next
//   cycle; no address is skipped or repeated beyond the hold.
// - HALTED: MicroPC held, RUNNING=0. START -> RUN at RESET_ADDR; other inputs are ignored.
// - START in RUN or WAIT is ignored.
// - rst in any state wins the same edge; any in-progress stall or stack contents are
//   discarded.
// CONFIGURATION
// - MICRO_STACK_EN defined: LIFO of STACK_DEPTH AW-bit entries. Stack actions occur only on
//   RUN cycles with MEMWAIT=0 and HALT=0. Priority is EN > CALL/RET > Z-branch > MicroAdd.
//   - CALL: push (MicroPC+1) mod 2^AW, jump to MicroAdd.
//   - RET: pop into MicroPC.
//   - CALL on full stack: jump taken, no push, STACK_ERR pulse.
//   - RET on empty stack: MicroPC=RESET_ADDR, STACK_ERR pulse.
//   - CALL&RET together: neither is executed, sequence to MicroAdd, STACK_ERR pulse.
// - MICRO_STACK_EN undefined: CALL and RET are ignored, STACK_ERR is tied 0, no stack
//   storage. Ports are identical in both builds.
// TESTING
// - rst, then START: MicroPC=00 on the START edge; MicroAdd=05 -> MicroPC=05 next cycle;
//   RUNNING=1.
// - ZEN=1, Z=1, MicroAdd=12 -> 92. ZEN=1, Z=0 -> 12. EN=1, IROUT=3C, ZEN=Z=1 -> 3C.
// - MEMWAIT high for 3 cycles at MicroPC=20: MicroPC stays 20 and STALL=1 for 3 cycles.
//   Then MicroAdd=21 -> MicroPC=21.
// - HALT=1 at MicroPC=40 -> HALTED, MicroPC stays 40, RUNNING=0. START -> MicroPC=00, RUN.
//   rst asserted mid-WAIT -> IDLE, MicroPC=00.
// - MICRO_STACK_EN: CALL at 10 (MicroAdd=80) -> 80; RET -> 11. Fifth nested CALL ->
//   STACK_ERR. RET on empty -> 00 with STACK_ERR. CALL&RET -> MicroAdd with STACK_ERR.
// - Stack build with MicroPC=FF and CALL: pushed return address wraps to 00.

Source files
------------

// File: rtl/micro_sequencer.sv
// Micro-program counter sequencer: start/halt control, memory-wait stalling and
// next-address selection. Optional micro-subroutine stack enabled by MICRO_STACK_EN.
module micro_sequencer #(
    parameter int unsigned     AW          = 8,
    parameter logic [AW-1:0]   RESET_ADDR  = AW'(0),
    parameter int unsigned     STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          START,
    input  logic          HALT,
    input  logic          MEMWAIT,
    input  logic          EN,
    input  logic          ZEN,
    input  logic          Z,
    input  logic          CALL,
    input  logic          RET,
    input  logic [AW-1:0] MicroAdd,
    input  logic [AW-1:0] IROUT,
    output logic [AW-1:0] MicroPC,
    output logic          RUNNING,
    output logic          STALL,
    output logic          STACK_ERR
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_WAIT   = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    localparam logic [AW-1:0] MSB_MASK = {1'b1, {(AW-1){1'b0}}};

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          running_q, running_d;
    logic          stall_q, stall_d;
    logic          err_q, err_d;
    logic [AW-1:0] zbr_addr_c;

    // Z-conditional branch flips the MSB of the next-address field
    assign zbr_addr_c = MicroAdd ^ MSB_MASK;

`ifdef MICRO_STACK_EN
    localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [AW-1:0]  stack_q [STACK_DEPTH];
    logic [SPW-1:0] sp_q, sp_d;
    logic           push_c, pop_c;
    logic           full_c, empty_c;
    logic [IW-1:0]  top_idx_c;
    logic [AW-1:0]  ret_addr_c;

    assign full_c     = (sp_q == SPW'(STACK_DEPTH));
    assign empty_c    = (sp_q == SPW'(0));
    assign top_idx_c  = IW'(sp_q - SPW'(1));
    assign ret_addr_c = AW'(pc_q + AW'(1));

    // Stack storage; contents need no reset since the pointer defines validity
    always_ff @(posedge clk) begin
        if (push_c) begin
            stack_q[IW'(sp_q)] <= ret_addr_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= SPW'(0);
        end else begin
            sp_q <= sp_d;
        end
    end
`else
    logic unused_c;
    assign unused_c = CALL ^ RET ^ (STACK_DEPTH == 0);
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_ADDR;
            running_q <= 1'b0;
            stall_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            stall_q   <= stall_d;
            err_q     <= err_d;
        end
    end

    // Next-state, next-address and stack control
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = 1'b0;
`ifdef MICRO_STACK_EN
        push_c  = 1'b0;
        pop_c   = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                pc_d = RESET_ADDR;
                if (START) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (MEMWAIT) begin
                    state_d = S_WAIT;
                end else if (HALT) begin
                    state_d = S_HALTED;
                end else if (EN) begin
                    pc_d = IROUT;
`ifdef MICRO_STACK_EN
                end else if (CALL && RET) begin
                    pc_d  = MicroAdd;
                    err_d = 1'b1;
                end else if (CALL) begin
                    pc_d = MicroAdd;
                    if (full_c) begin
                        err_d = 1'b1;
                    end else begin
                        push_c = 1'b1;
                    end
                end else if (RET) begin
                    if (empty_c) begin
                        pc_d  = RESET_ADDR;
                        err_d = 1'b1;
                    end else begin
                        pc_d  = stack_q[top_idx_c];
                        pop_c = 1'b1;
                    end
`endif
                end else if (ZEN && Z) begin
                    pc_d = zbr_addr_c;
                end else begin
                    pc_d = MicroAdd;
                end
            end
            S_WAIT: begin
                if (!MEMWAIT) begin
                    state_d = S_RUN;
                end
            end
            S_HALTED: begin
                if (START) begin
                    state_d = S_RUN;
                    pc_d    = RESET_ADDR;
                end
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = RESET_ADDR;
            end
        endcase

        running_d = (state_d == S_RUN) || (state_d == S_WAIT);
        stall_d   = (state_d == S_WAIT);

`ifdef MICRO_STACK_EN
        sp_d = sp_q;
        if (push_c) begin
            sp_d = SPW'(sp_q + SPW'(1));
        end else if (pop_c) begin
            sp_d = SPW'(sp_q - SPW'(1));
        end
`endif
    end

    assign MicroPC   = pc_q;
    assign RUNNING   = running_q;
    assign STALL     = stall_q;
    assign STACK_ERR = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed vector bench for micro_sequencer; stack vectors apply when MICRO_STACK_EN is defined.
module tb_micro_sequencer;

    typedef struct {
        string      name;
        logic       rst;
        logic       start;
        logic       halt;
        logic       memwait;
        logic       en;
        logic       zen;
        logic       z;
        logic       call;
        logic       ret;
        logic [7:0] madd;
        logic [7:0] irout;
        logic [7:0] exp_pc;
        logic       exp_run;
        logic       exp_stall;
        logic       exp_err;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       START, HALT, MEMWAIT, EN, ZEN, Z, CALL, RET;
    logic [7:0] MicroAdd, IROUT;
    logic [7:0] MicroPC;
    logic       RUNNING, STALL, STACK_ERR;

    vec_t vecs [64];
    int   nvec;
    int   total;
    int   bad;

    micro_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .START     (START),
        .HALT      (HALT),
        .MEMWAIT   (MEMWAIT),
        .EN        (EN),
        .ZEN       (ZEN),
        .Z         (Z),
        .CALL      (CALL),
        .RET       (RET),
        .MicroAdd  (MicroAdd),
        .IROUT     (IROUT),
        .MicroPC   (MicroPC),
        .RUNNING   (RUNNING),
        .STALL     (STALL),
        .STACK_ERR (STACK_ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input string nm, input logic r, input logic st, input logic h,
                       input logic mw, input logic e, input logic ze, input logic zz,
                       input logic c, input logic rt, input logic [7:0] ma,
                       input logic [7:0] ir, input logic [7:0] epc, input logic erun,
                       input logic estall, input logic eerr);
        vec_t v;
        v.name = nm; v.rst = r; v.start = st; v.halt = h; v.memwait = mw;
        v.en = e; v.zen = ze; v.z = zz; v.call = c; v.ret = rt;
        v.madd = ma; v.irout = ir;
        v.exp_pc = epc; v.exp_run = erun; v.exp_stall = estall; v.exp_err = eerr;
        vecs[nvec] = v;
        nvec++;
    endtask

    task automatic check_bit(input string nm, input string sig, input logic got,
                             input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s %s: got %b want %b", nm, sig, got, want);
        end
    endtask

    initial begin
        nvec = 0; total = 0; bad = 0;
        rst = 1'b0; START = 1'b0; HALT = 1'b0; MEMWAIT = 1'b0; EN = 1'b0;
        ZEN = 1'b0; Z = 1'b0; CALL = 1'b0; RET = 1'b0;
        MicroAdd = 8'h00; IROUT = 8'h00;

        //      name            rst st h mw en ze z c r madd   irout  pc     run stl err
        add("reset",            1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add("idle_hold",        0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h33, 8'h00, 8'h00, 0, 0, 0);
        add("start",            0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h05, 8'h00, 8'h00, 1, 0, 0);
        add("seq_05",           0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h05, 8'h00, 8'h05, 1, 0, 0);
        add("zbr_taken",        0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h12, 8'h00, 8'h92, 1, 0, 0);
        add("zbr_not_taken",    0, 0, 0, 0, 0, 1, 0, 0, 0, 8'h12, 8'h00, 8'h12, 1, 0, 0);
        add("dispatch_prio",    0, 0, 0, 0, 1, 1, 1, 0, 0, 8'h12, 8'h3C, 8'h3C, 1, 0, 0);
        add("seq_20",           0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h20, 8'h00, 8'h20, 1, 0, 0);
        add("wait_1",           0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h21, 8'h00, 8'h20, 1, 1, 0);
        add("wait_2",           0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h21, 8'h00, 8'h20, 1, 1, 0);
        add("wait_3",           0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h21, 8'h00, 8'h20, 1, 1, 0);
        add("wait_release",     0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h21, 8'h00, 8'h20, 1, 0, 0);
        add("seq_21",           0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h21, 8'h00, 8'h21, 1, 0, 0);
        add("start_in_run",     0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h40, 8'h00, 8'h40, 1, 0, 0);
        add("halt",             0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h55, 8'h00, 8'h40, 0, 0, 0);
        add("halted_ignore",    0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h66, 8'h77, 8'h40, 0, 0, 0);
        add("restart",          0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h66, 8'h00, 8'h00, 1, 0, 0);
        add("zbr_7f",           0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h7F, 8'h00, 8'hFF, 1, 0, 0);
        add("memwait_over_halt",0, 0, 1, 1, 0, 0, 0, 0, 0, 8'h01, 8'h00, 8'hFF, 1, 1, 0);
        add("wait_exit_hold",   0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h01, 8'h00, 8'hFF, 1, 0, 0);
        add("halt_2",           0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h01, 8'h00, 8'hFF, 0, 0, 0);
        add("restart_2",        0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h01, 8'h00, 8'h00, 1, 0, 0);
        add("wait_again",       0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h01, 8'h00, 8'h00, 1, 1, 0);
        add("rst_mid_wait",     1, 0, 0, 1, 0, 0, 0, 0, 0, 8'h01, 8'h00, 8'h00, 0, 0, 0);
        add("idle_after_rst",   0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h09, 8'h00, 8'h00, 0, 0, 0);
        add("restart_3",        0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h09, 8'h00, 8'h00, 1, 0, 0);
        add("seq_10",           0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'h10, 1, 0, 0);
`ifdef MICRO_STACK_EN
        add("call_10",          0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h80, 8'h00, 8'h80, 1, 0, 0);
        add("ret_11",           0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h33, 8'h00, 8'h11, 1, 0, 0);
        add("ret_empty",        0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h33, 8'h00, 8'h00, 1, 0, 1);
        add("err_pulse_end",    0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'h10, 1, 0, 0);
        add("call_n1",          0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h20, 8'h00, 8'h20, 1, 0, 0);
        add("call_n2",          0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h30, 8'h00, 8'h30, 1, 0, 0);
        add("call_n3",          0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h40, 8'h00, 8'h40, 1, 0, 0);
        add("call_n4",          0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h50, 8'h00, 8'h50, 1, 0, 0);
        add("call_overflow",    0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h60, 8'h00, 8'h60, 1, 0, 1);
        add("ret_41",           0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h41, 1, 0, 0);
        add("call_ret_conf",    0, 0, 0, 0, 0, 0, 0, 1, 1, 8'h77, 8'h00, 8'h77, 1, 0, 1);
        add("ret_31",           0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h31, 1, 0, 0);
        add("ret_21",           0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h21, 1, 0, 0);
        add("ret_11b",          0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h11, 1, 0, 0);
        add("ret_empty_2",      0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 1, 0, 1);
        add("seq_ff",           0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hFF, 8'h00, 8'hFF, 1, 0, 0);
        add("call_at_ff",       0, 0, 0, 0, 0, 0, 0, 1, 0, 8'hAA, 8'h00, 8'hAA, 1, 0, 0);
        add("ret_wrap_00",      0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        add("en_over_call",     0, 0, 0, 0, 1, 0, 0, 1, 0, 8'h99, 8'h5A, 8'h5A, 1, 0, 0);
        add("ret_empty_3",      0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 1, 0, 1);
`else
        add("call_ignored",     0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h22, 8'h00, 8'h22, 1, 0, 0);
        add("ret_ignored",      0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h23, 8'h00, 8'h23, 1, 0, 0);
        add("call_ret_ignored", 0, 0, 0, 0, 0, 1, 1, 1, 1, 8'h24, 8'h00, 8'hA4, 1, 0, 0);
`endif

        for (int i = 0; i < nvec; i++) begin
            rst      = vecs[i].rst;
            START    = vecs[i].start;
            HALT     = vecs[i].halt;
            MEMWAIT  = vecs[i].memwait;
            EN       = vecs[i].en;
            ZEN      = vecs[i].zen;
            Z        = vecs[i].z;
            CALL     = vecs[i].call;
            RET      = vecs[i].ret;
            MicroAdd = vecs[i].madd;
            IROUT    = vecs[i].irout;
            @(posedge clk);
            #1;
            total++;
            if (MicroPC !== vecs[i].exp_pc) begin
                bad++;
                $display("FAIL %s MicroPC: got %h want %h", vecs[i].name, MicroPC,
                         vecs[i].exp_pc);
            end
            check_bit(vecs[i].name, "RUNNING", RUNNING, vecs[i].exp_run);
            check_bit(vecs[i].name, "STALL", STALL, vecs[i].exp_stall);
            check_bit(vecs[i].name, "STACK_ERR", STACK_ERR, vecs[i].exp_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
